// File: rtl/lsu_apb_bridge.sv
// LSU-to-APB4 bridge: turns a single registered LSU request from the
// external-memory channel into one APB4 transfer and returns a one-cycle ack.

package SOPHON_PKG;
   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  amo;
      logic [3:0]  strb;
      logic [1:0]  size;
   } lsu_req_t;

   typedef struct packed {
      logic        ack;
      logic        error;
      logic [31:0] rdata;
   } lsu_ack_t;
endpackage

module lsu_apb_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  SOPHON_PKG::lsu_req_t lsu_req_i,
   output SOPHON_PKG::lsu_ack_t lsu_ack_o,
   output logic [31:0]          paddr_o,
   output logic                 psel_o,
   output logic                 penable_o,
   output logic                 pwrite_o,
   output logic [31:0]          pwdata_o,
   output logic [3:0]           pstrb_o,
   output logic [2:0]           pprot_o,
   input  logic [31:0]          prdata_i,
   input  logic                 pready_i,
   input  logic                 pslverr_i
);

   // A zero timeout still needs a 1-bit counter so the logic stays legal.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t            state_q, state_d;
   logic [31:0]       paddr_q, paddr_d;
   logic [31:0]       pwdata_q, pwdata_d;
   logic [3:0]        pstrb_q, pstrb_d;
   logic              pwrite_q, pwrite_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              unused_addr_lsbs;

   // APB addresses are word aligned, so the byte offset is dropped.
   assign unused_addr_lsbs = ^lsu_req_i.addr[1:0];

   // Next-state logic: latch the request once in IDLE, then walk SETUP/ACCESS/RESP.
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      pwrite_d = pwrite_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (lsu_req_i.req) begin
               if ((lsu_req_i.amo != 4'd0) || (lsu_req_i.size > 2'd2)) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  paddr_d  = {lsu_req_i.addr[31:2], 2'b00};
                  pwrite_d = lsu_req_i.we;
                  pwdata_d = lsu_req_i.wdata;
                  pstrb_d  = lsu_req_i.we ? lsu_req_i.strb : 4'b0000;
                  err_d    = 1'b0;
                  cnt_d    = '0;
                  state_d  = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               if (!pwrite_q) begin
                  rdata_d = prdata_i;
               end
               err_d   = pslverr_i;
               state_d = RESP;
            end else begin
               cnt_d = cnt_inc;
               if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_LIMIT)) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         pwrite_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         pwrite_q <= pwrite_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   // APB and ack outputs decode straight from the state so reset drops them at once.
   always_comb begin
      psel_o          = (state_q == SETUP) || (state_q == ACCESS);
      penable_o       = (state_q == ACCESS);
      paddr_o         = paddr_q;
      pwrite_o        = pwrite_q;
      pwdata_o        = pwdata_q;
      pstrb_o         = pstrb_q;
      pprot_o         = PPROT_VAL;
      lsu_ack_o.ack   = (state_q == RESP);
      lsu_ack_o.error = (state_q == RESP) && err_q;
      lsu_ack_o.rdata = rdata_q;
   end

endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Directed testbench for lsu_apb_bridge: a vector table of single transfers
// plus hand-written reset and timeout sequences.

module tb_lsu_apb_bridge;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   SOPHON_PKG::lsu_req_t lsu_req;
   SOPHON_PKG::lsu_ack_t lsu_ack;
   logic [31:0]          paddr, pwdata, prdata;
   logic                 psel, penable, pwrite, pready, pslverr;
   logic [3:0]           pstrb;
   logic [2:0]           pprot;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [3:0]  amo;
      logic [1:0]  size;
      logic [31:0] prdata;
      int          waits;
      logic        slverr;
      logic        exp_sel;
      logic [31:0] exp_paddr;
      logic        exp_pwrite;
      logic [3:0]  exp_pstrb;
      int          exp_lat;
      int          exp_access;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   lsu_apb_bridge #(
      .TIMEOUT_CYCLES(4),
      .PPROT_VAL     (3'b010)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .lsu_req_i(lsu_req),
      .lsu_ack_o(lsu_ack),
      .paddr_o  (paddr),
      .psel_o   (psel),
      .penable_o(penable),
      .pwrite_o (pwrite),
      .pwdata_o (pwdata),
      .pstrb_o  (pstrb),
      .pprot_o  (pprot),
      .prdata_i (prdata),
      .pready_i (pready),
      .pslverr_i(pslverr)
   );

   // Compare one observed value against its expected value and tally the result.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Run one LSU request from IDLE, acting as the APB slave, and check the result.
   task automatic applyStimulus(input vec_t v);
      int          lat;
      int          acc;
      logic        saw_sel;
      logic        ack_err;
      logic [31:0] ack_rdata;
      lat       = -1;
      acc       = 0;
      saw_sel   = 1'b0;
      ack_err   = 1'b0;
      ack_rdata = '0;
      lsu_req.req   = 1'b1;
      lsu_req.we    = v.we;
      lsu_req.addr  = v.addr;
      lsu_req.wdata = v.wdata;
      lsu_req.strb  = v.strb;
      lsu_req.amo   = v.amo;
      lsu_req.size  = v.size;
      prdata  = v.prdata;
      pready  = 1'b0;
      pslverr = 1'b0;
      for (int c = 1; c <= 20 && lat < 0; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 1) begin
            lsu_req.req   = 1'b0;
            lsu_req.we    = ~v.we;
            lsu_req.addr  = ~v.addr;
            lsu_req.wdata = ~v.wdata;
            lsu_req.strb  = ~v.strb;
         end
         pready  = 1'b0;
         pslverr = 1'b0;
         if (psel && !penable) begin
            saw_sel = 1'b1;
            checkOutput("setup_paddr", paddr, v.exp_paddr);
            checkOutput("setup_pwrite", {31'd0, pwrite}, {31'd0, v.exp_pwrite});
            checkOutput("setup_pstrb", {28'd0, pstrb}, {28'd0, v.exp_pstrb});
            if (v.we) checkOutput("setup_pwdata", pwdata, v.wdata);
         end else if (psel && penable) begin
            checkOutput("access_paddr", paddr, v.exp_paddr);
            if (acc == v.waits) begin
               pready  = 1'b1;
               pslverr = v.slverr;
            end
            acc++;
         end else if (lsu_ack.ack) begin
            lat       = c;
            ack_err   = lsu_ack.error;
            ack_rdata = lsu_ack.rdata;
         end
      end
      pready  = 1'b0;
      pslverr = 1'b0;
      checkOutput("ack_latency", lat, v.exp_lat);
      checkOutput("access_cycles", acc, v.exp_access);
      checkOutput("psel_seen", {31'd0, saw_sel}, {31'd0, v.exp_sel});
      checkOutput("ack_error", {31'd0, ack_err}, {31'd0, v.exp_err});
      checkOutput("ack_rdata", ack_rdata, v.exp_rdata);
      for (int h = 0; h < 2; h++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("post_ack", {29'd0, lsu_ack.ack, lsu_ack.error, psel}, 32'd0);
         checkOutput("rdata_hold", lsu_ack.rdata, v.exp_rdata);
      end
   endtask

   initial begin
      int acks_after_reset;

      vecs[0] = '{we:1'b0, addr:32'h9000_1006, wdata:32'h0, strb:4'h0, amo:4'h0, size:2'd1,
                  prdata:32'hCAFE_BABE, waits:0, slverr:1'b0, exp_sel:1'b1,
                  exp_paddr:32'h9000_1004, exp_pwrite:1'b0, exp_pstrb:4'h0,
                  exp_lat:3, exp_access:1, exp_err:1'b0, exp_rdata:32'hCAFE_BABE};
      vecs[1] = '{we:1'b1, addr:32'h4000_0010, wdata:32'h1234_5678, strb:4'b1100, amo:4'h0, size:2'd2,
                  prdata:32'hDEAD_BEEF, waits:2, slverr:1'b0, exp_sel:1'b1,
                  exp_paddr:32'h4000_0010, exp_pwrite:1'b1, exp_pstrb:4'b1100,
                  exp_lat:5, exp_access:3, exp_err:1'b0, exp_rdata:32'hCAFE_BABE};
      vecs[2] = '{we:1'b0, addr:32'h8000_0003, wdata:32'h0, strb:4'h0, amo:4'h0, size:2'd0,
                  prdata:32'h1111_2222, waits:1, slverr:1'b1, exp_sel:1'b1,
                  exp_paddr:32'h8000_0000, exp_pwrite:1'b0, exp_pstrb:4'h0,
                  exp_lat:4, exp_access:2, exp_err:1'b1, exp_rdata:32'h1111_2222};
      vecs[3] = '{we:1'b0, addr:32'h0000_0FFC, wdata:32'h0, strb:4'h0, amo:4'h0, size:2'd2,
                  prdata:32'hA5A5_5A5A, waits:0, slverr:1'b0, exp_sel:1'b1,
                  exp_paddr:32'h0000_0FFC, exp_pwrite:1'b0, exp_pstrb:4'h0,
                  exp_lat:3, exp_access:1, exp_err:1'b0, exp_rdata:32'hA5A5_5A5A};
      vecs[4] = '{we:1'b0, addr:32'h0000_0100, wdata:32'h0, strb:4'h0, amo:4'h2, size:2'd2,
                  prdata:32'h7777_7777, waits:0, slverr:1'b0, exp_sel:1'b0,
                  exp_paddr:32'h0, exp_pwrite:1'b0, exp_pstrb:4'h0,
                  exp_lat:1, exp_access:0, exp_err:1'b1, exp_rdata:32'hA5A5_5A5A};
      vecs[5] = '{we:1'b1, addr:32'h0000_0200, wdata:32'h5555_AAAA, strb:4'hF, amo:4'h0, size:2'd3,
                  prdata:32'h7777_7777, waits:0, slverr:1'b0, exp_sel:1'b0,
                  exp_paddr:32'h0, exp_pwrite:1'b0, exp_pstrb:4'h0,
                  exp_lat:1, exp_access:0, exp_err:1'b1, exp_rdata:32'hA5A5_5A5A};
      vecs[6] = '{we:1'b0, addr:32'h1234_5679, wdata:32'h0, strb:4'hF, amo:4'h0, size:2'd0,
                  prdata:32'h0F0F_0F0F, waits:1, slverr:1'b0, exp_sel:1'b1,
                  exp_paddr:32'h1234_5678, exp_pwrite:1'b0, exp_pstrb:4'h0,
                  exp_lat:4, exp_access:2, exp_err:1'b0, exp_rdata:32'h0F0F_0F0F};
      vecs[7] = '{we:1'b0, addr:32'hA000_0020, wdata:32'h0, strb:4'h0, amo:4'h0, size:2'd2,
                  prdata:32'hFFFF_FFFF, waits:99, slverr:1'b0, exp_sel:1'b1,
                  exp_paddr:32'hA000_0020, exp_pwrite:1'b0, exp_pstrb:4'h0,
                  exp_lat:6, exp_access:4, exp_err:1'b1, exp_rdata:32'h0F0F_0F0F};

      lsu_req = '0;
      prdata  = '0;
      pready  = 1'b0;
      pslverr = 1'b0;

      #1;
      checkOutput("reset_psel_penable", {30'd0, psel, penable}, 32'd0);
      checkOutput("reset_paddr", paddr, 32'd0);
      checkOutput("reset_pwdata", pwdata, 32'd0);
      checkOutput("reset_pstrb_pwrite", {27'd0, pstrb, pwrite}, 32'd0);
      checkOutput("reset_ack", {30'd0, lsu_ack.ack, lsu_ack.error}, 32'd0);
      checkOutput("reset_rdata", lsu_ack.rdata, 32'd0);
      checkOutput("pprot", {29'd0, pprot}, 32'd2);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
      end

      // Reset pulse in the middle of an ACCESS phase must drop PSEL at once.
      lsu_req.req  = 1'b1;
      lsu_req.we   = 1'b0;
      lsu_req.addr = 32'h2000_0008;
      lsu_req.amo  = 4'h0;
      lsu_req.size = 2'd2;
      @(posedge clk);
      @(negedge clk);
      lsu_req.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("pre_reset_access", {30'd0, psel, penable}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_psel", {30'd0, psel, penable}, 32'd0);
      checkOutput("async_reset_ack", {31'd0, lsu_ack.ack}, 32'd0);
      checkOutput("async_reset_rdata", lsu_ack.rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      acks_after_reset = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (lsu_ack.ack || psel) acks_after_reset++;
      end
      checkOutput("no_ack_after_reset", acks_after_reset, 0);

      applyStimulus(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
